sc_comp_dataflow: RTL and testbench
===================================

Name: sc_comp_dataflow

Overview:
Single-cycle MIPS-I subset computer: CPU core, instruction ROM and data RAM in one top level. One instruction completes per clk_in rising edge. Exposes current PC and instruction for debug. Serves as the top-level DUT for program-trace simulation against a MARS-style golden register dump.

Parameters:
IMEM_DEPTH, 1024, instruction ROM words.
DMEM_DEPTH, 1024, data RAM words.
IMEM_INIT, "imem.hex", hex file loaded into the ROM at time 0 ($readmemh).
PC_RESET, 32'h0040_0000, PC value after reset (MARS text base).
DMEM_BASE, 32'h1001_0000, byte address of data RAM word 0.

Ports:
clk_in  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
pc  output  32  current instruction byte address.
inst  output  32  instruction word at pc.

Behaviour:
- Reset (reset=0, asynchronous): PC=PC_RESET; all 32 GPRs=0; data RAM is not cleared. pc reads PC_RESET and inst reads ROM[0] combinationally while reset is held.
- Fetch: ROM index = (pc-PC_RESET)>>2, truncated to log2(IMEM_DEPTH) bits (wraps). Combinational read.
- Hierarchy names, fixed for debug probes: top-level wires instr_addr_read (=pc) and instruction (=inst); core instance sccpu; register file instance sccpu.cpu_ref; storage array array_reg[0:31], 32-bit.
- Register file: 2 combinational read ports, 1 write port on the rising edge. Writes to $0 are ignored, so $0 always reads 0.
- Supported R-type ops: addu, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, jr.
- Supported I/J-type ops: addiu, andi, ori, xori, lui, slti, sltiu, lw, sw, beq, bne, j, jal.
- Any other encoding executes as a NOP: PC+4, no writes.
- Arithmetic is 32-bit modulo with no overflow traps; add/addi are not required.
- Immediate extension: andi/ori/xori zero-extend. All other I-type ops sign-extend.
- lui: rt = imm<<16.
- Shifts: shift amount is shamt, or rs[4:0] for the v-forms. sra is arithmetic.
- slt/slti compare signed; sltu/sltiu compare unsigned (sltiu uses the sign-extended immediate).
- Next PC, default: PC+4.
- beq/bne taken: PC+4+(sext(imm)<<2).
- j/jal: {PC+4[31:28], target, 2'b00}. jal writes PC+4 to $31.
- jr: rs.
- There are no delay slots.
- Memory: lw/sw address = rs+sext(imm). RAM index = (addr-DMEM_BASE)>>2, word-aligned; low 2 bits ignored; index wraps modulo DMEM_DEPTH.
- sw writes RAM on the rising edge. lw reads combinationally and writes rt on the same edge.
- Single cycle: every architectural update (PC, GPR, RAM) commits on the same rising edge. Latency is 1 cycle per instruction.
- Reset asserted mid-program: immediate return to reset state; any in-flight write is discarded.

Decomposition:
- Shared package mips_pkg: opcode/funct localparams, ALU-op enum, PC_RESET/DMEM_BASE defaults.
- One natural sub-module: sc_cpu_core, instanced as sccpu. It contains the control decode, ALU, next-PC logic and the register file instance cpu_ref.
- ROM and RAM are inferred arrays in the top level.

Test Plan:
- Reset held 2 cycles, then released -> pc=00400000, all array_reg=0, inst=ROM[0].
- Program "lui $1,0x1234; ori $1,$1,0x5678; addiu $2,$0,-1; addu $3,$1,$2" -> after 4 edges: $1=12345678, $2=ffffffff, $3=12345677, pc=00400010.
- "addiu $4,$0,-8; sra $5,$4,1; srl $6,$4,28; slt $7,$4,$0; sltu $8,$4,$0" -> $5=fffffffc, $6=0000000f, $7=1, $8=0.
- Memory path: "lui $9,0x1001; addiu $10,$0,0x55; sw $10,4($9); lw $11,4($9)" -> $11=00000055.
- Control flow: beq $0,$0,+2 at 00400000 -> pc=0040000c. jal to 0x00400100 -> $31=pc_jal+4. jr $31 returns to that value. addiu $0,$0,5 leaves $0=0.
- Async reset asserted between edges mid-program -> pc=00400000 and registers=0 immediately, without waiting for a clock edge. Execution resumes from ROM[0] after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, ALU operations and decode bundle
// for the single-cycle MIPS-I subset computer.
package mips_pkg;

   localparam logic [31:0] PC_RESET_DEF  = 32'h0040_0000;
   localparam logic [31:0] DMEM_BASE_DEF = 32'h1001_0000;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2a;
   localparam logic [5:0] FN_SLTU = 6'h2b;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } alu_op_e;

   typedef enum logic [1:0] {
      W_RD, W_RT, W_RA
   } wsel_e;

   typedef struct packed {
      alu_op_e alu_op;
      wsel_e   wsel;
      logic    reg_we;
      logic    b_imm;
      logic    zext;
      logic    shv;
      logic    mem_we;
      logic    mem_rd;
      logic    beq;
      logic    bne;
      logic    jump;
      logic    jal;
      logic    jr;
   } ctrl_t;

endpackage

// File: rtl/sc_cpu_core.sv
// Single-cycle MIPS-I subset core: decode, ALU, next-PC, GPRs.
// Ports: clk_in/reset, inst_i, pc_o, data RAM addr/wdata/we/rdata.
module sc_cpu_core
   import mips_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic [31:0] inst_i,
   input  logic [31:0] dmem_rdata_i,
   output logic [31:0] pc_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic        dmem_we_o
);

   logic [31:0] pc_q, pc_d, pc4;
   ctrl_t       ctrl;
   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd, sa;
   logic [15:0] imm;
   logic [31:0] rs_v, rt_v, imm_x, alu_b, alu_y;
   logic [31:0] wd;
   logic [4:0]  wa, sh;
   logic        eq, take;

   assign op  = inst_i[31:26];
   assign rs  = inst_i[25:21];
   assign rt  = inst_i[20:16];
   assign rd  = inst_i[15:11];
   assign sa  = inst_i[10:6];
   assign fn  = inst_i[5:0];
   assign imm = inst_i[15:0];

   always_comb begin
      ctrl        = '0;
      ctrl.alu_op = ALU_ADD;
      ctrl.wsel   = W_RT;
      unique case (op)
         OP_RTYPE: begin
            ctrl.reg_we = 1'b1;
            ctrl.wsel   = W_RD;
            unique case (fn)
               FN_ADDU: ctrl.alu_op = ALU_ADD;
               FN_SUBU: ctrl.alu_op = ALU_SUB;
               FN_AND:  ctrl.alu_op = ALU_AND;
               FN_OR:   ctrl.alu_op = ALU_OR;
               FN_XOR:  ctrl.alu_op = ALU_XOR;
               FN_NOR:  ctrl.alu_op = ALU_NOR;
               FN_SLT:  ctrl.alu_op = ALU_SLT;
               FN_SLTU: ctrl.alu_op = ALU_SLTU;
               FN_SLL:  ctrl.alu_op = ALU_SLL;
               FN_SRL:  ctrl.alu_op = ALU_SRL;
               FN_SRA:  ctrl.alu_op = ALU_SRA;
               FN_SLLV: begin
                  ctrl.alu_op = ALU_SLL;
                  ctrl.shv    = 1'b1;
               end
               FN_SRLV: begin
                  ctrl.alu_op = ALU_SRL;
                  ctrl.shv    = 1'b1;
               end
               FN_SRAV: begin
                  ctrl.alu_op = ALU_SRA;
                  ctrl.shv    = 1'b1;
               end
               FN_JR: begin
                  ctrl.reg_we = 1'b0;
                  ctrl.jr     = 1'b1;
               end
               default: ctrl.reg_we = 1'b0;
            endcase
         end
         OP_ADDIU: begin
            ctrl.reg_we = 1'b1;
            ctrl.b_imm  = 1'b1;
         end
         OP_SLTI: begin
            ctrl.reg_we = 1'b1;
            ctrl.b_imm  = 1'b1;
            ctrl.alu_op = ALU_SLT;
         end
         OP_SLTIU: begin
            ctrl.reg_we = 1'b1;
            ctrl.b_imm  = 1'b1;
            ctrl.alu_op = ALU_SLTU;
         end
         OP_ANDI: begin
            ctrl.reg_we = 1'b1;
            ctrl.b_imm  = 1'b1;
            ctrl.zext   = 1'b1;
            ctrl.alu_op = ALU_AND;
         end
         OP_ORI: begin
            ctrl.reg_we = 1'b1;
            ctrl.b_imm  = 1'b1;
            ctrl.zext   = 1'b1;
            ctrl.alu_op = ALU_OR;
         end
         OP_XORI: begin
            ctrl.reg_we = 1'b1;
            ctrl.b_imm  = 1'b1;
            ctrl.zext   = 1'b1;
            ctrl.alu_op = ALU_XOR;
         end
         OP_LUI: begin
            ctrl.reg_we = 1'b1;
            ctrl.b_imm  = 1'b1;
            ctrl.alu_op = ALU_LUI;
         end
         OP_LW: begin
            ctrl.reg_we = 1'b1;
            ctrl.b_imm  = 1'b1;
            ctrl.mem_rd = 1'b1;
         end
         OP_SW: begin
            ctrl.b_imm  = 1'b1;
            ctrl.mem_we = 1'b1;
         end
         OP_BEQ: ctrl.beq = 1'b1;
         OP_BNE: ctrl.bne = 1'b1;
         OP_J:   ctrl.jump = 1'b1;
         OP_JAL: begin
            ctrl.jump   = 1'b1;
            ctrl.jal    = 1'b1;
            ctrl.reg_we = 1'b1;
            ctrl.wsel   = W_RA;
         end
         default: ctrl = ctrl;
      endcase
   end

   sc_regfile cpu_ref (
      .clk_in (clk_in),
      .reset  (reset),
      .ra1_i  (rs),
      .ra2_i  (rt),
      .we_i   (ctrl.reg_we),
      .wa_i   (wa),
      .wd_i   (wd),
      .rd1_o  (rs_v),
      .rd2_o  (rt_v)
   );

   assign imm_x = ctrl.zext ? {16'h0, imm}
                            : {{16{imm[15]}}, imm};
   assign alu_b = ctrl.b_imm ? imm_x : rt_v;
   assign sh    = ctrl.shv ? rs_v[4:0] : sa;

   always_comb begin
      unique case (ctrl.alu_op)
         ALU_ADD:  alu_y = rs_v + alu_b;
         ALU_SUB:  alu_y = rs_v - alu_b;
         ALU_AND:  alu_y = rs_v & alu_b;
         ALU_OR:   alu_y = rs_v | alu_b;
         ALU_XOR:  alu_y = rs_v ^ alu_b;
         ALU_NOR:  alu_y = ~(rs_v | alu_b);
         ALU_SLT:  alu_y = {31'h0,
                      $signed(rs_v) < $signed(alu_b)};
         ALU_SLTU: alu_y = {31'h0, rs_v < alu_b};
         ALU_SLL:  alu_y = alu_b << sh;
         ALU_SRL:  alu_y = alu_b >> sh;
         ALU_SRA:  alu_y = $unsigned($signed(alu_b) >>> sh);
         ALU_LUI:  alu_y = {alu_b[15:0], 16'h0};
         default:  alu_y = '0;
      endcase
   end

   assign pc4 = pc_q + 32'd4;

   always_comb begin
      unique case (ctrl.wsel)
         W_RD:    wa = rd;
         W_RA:    wa = 5'd31;
         default: wa = rt;
      endcase
   end

   assign wd = ctrl.jal    ? pc4 :
               ctrl.mem_rd ? dmem_rdata_i : alu_y;

   assign eq   = (rs_v == rt_v);
   assign take = (ctrl.beq & eq) | (ctrl.bne & ~eq);

   always_comb begin
      pc_d = pc4;
      if (ctrl.jr) begin
         pc_d = rs_v;
      end else if (ctrl.jump) begin
         pc_d = {pc4[31:28], inst_i[25:0], 2'b00};
      end else if (take) begin
         pc_d = pc4 + {{14{imm[15]}}, imm, 2'b00};
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         pc_q <= PC_RESET;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o         = pc_q;
   assign dmem_addr_o  = alu_y;
   assign dmem_wdata_o = rt_v;
   assign dmem_we_o    = ctrl.mem_we;

endmodule

// File: rtl/sc_regfile.sv
// 32x32 GPR file: two combinational read ports, one write port.
// Ports: clk_in/reset, ra1_i/ra2_i -> rd1_o/rd2_o, we_i/wa_i/wd_i.
module sc_regfile (
   input  logic        clk_in,
   input  logic        reset,
   input  logic [4:0]  ra1_i,
   input  logic [4:0]  ra2_i,
   input  logic        we_i,
   input  logic [4:0]  wa_i,
   input  logic [31:0] wd_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o
);

   logic [31:0] array_reg [0:31];

   // $0 is cleared by reset and never written, so it reads 0
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            array_reg[i] <= '0;
         end
      end else if (we_i && (wa_i != 5'd0)) begin
         array_reg[wa_i] <= wd_i;
      end
   end

   assign rd1_o = array_reg[ra1_i];
   assign rd2_o = array_reg[ra2_i];

endmodule

// File: rtl/sc_comp_dataflow.sv
// Single-cycle computer: sc_cpu_core plus instruction ROM and data RAM.
// Ports: clk_in, reset (async, active low), pc and inst for debug.
module sc_comp_dataflow
   import mips_pkg::*;
#(
   parameter int          IMEM_DEPTH = 1024,
   parameter int          DMEM_DEPTH = 1024,
   parameter string       IMEM_INIT  = "imem.hex",
   parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
   parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF
) (
   input  logic        clk_in,
   input  logic        reset,
   output logic [31:0] pc,
   output logic [31:0] inst
);

   localparam int IW = $clog2(IMEM_DEPTH);
   localparam int DW = $clog2(DMEM_DEPTH);

   logic [31:0] imem [0:IMEM_DEPTH-1];
   logic [31:0] dmem [0:DMEM_DEPTH-1];

   logic [31:0] instr_addr_read;
   logic [31:0] instruction;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        d_we;
   logic [IW-1:0] i_idx;
   logic [DW-1:0] d_idx;

   // word indices wrap within each memory
   assign i_idx = IW'((instr_addr_read - PC_RESET) >> 2);
   assign d_idx = DW'((d_addr - DMEM_BASE) >> 2);

   assign instruction = imem[i_idx];
   assign d_rdata     = dmem[d_idx];

   // no store commits while reset is held
   always_ff @(posedge clk_in) begin
      if (d_we && reset) begin
         dmem[d_idx] <= d_wdata;
      end
   end

   sc_cpu_core #(
      .PC_RESET (PC_RESET)
   ) sccpu (
      .clk_in       (clk_in),
      .reset        (reset),
      .inst_i       (instruction),
      .dmem_rdata_i (d_rdata),
      .pc_o         (instr_addr_read),
      .dmem_addr_o  (d_addr),
      .dmem_wdata_o (d_wdata),
      .dmem_we_o    (d_we)
   );

   assign pc   = instr_addr_read;
   assign inst = instruction;

endmodule

// File: tb/tb_sc_comp_dataflow.sv
// Directed program bench for sc_comp_dataflow with a
// scoreboard queue checked by a separate negedge monitor.
module tb_sc_comp_dataflow;

   localparam int K_PC   = 0;
   localparam int K_INST = 1;
   localparam int K_REG  = 2;
   localparam int K_MEM  = 3;

   typedef struct {
      int          kind;
      int          idx;
      logic [31:0] exp;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc, inst;

   exp_t sbq[$];
   int   n_chk = 0;
   int   n_fail = 0;

   sc_comp_dataflow #(
      .IMEM_INIT ("")
   ) dut (
      .clk_in (clk),
      .reset  (rst_n),
      .pc     (pc),
      .inst   (inst)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] r_op(
      input int s, input int t, input int d,
      input int sa, input logic [5:0] fn);
      r_op = {6'd0, 5'(s), 5'(t), 5'(d), 5'(sa), fn};
   endfunction

   function automatic logic [31:0] i_op(
      input logic [5:0] op, input int s, input int t,
      input logic [15:0] imm);
      i_op = {op, 5'(s), 5'(t), imm};
   endfunction

   function automatic logic [31:0] j_op(
      input logic [5:0] op, input logic [31:0] addr);
      j_op = {op, addr[27:2]};
   endfunction

   // monitor: compares every queued expectation at negedge
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         case (e.kind)
            K_PC:    act = pc;
            K_INST:  act = inst;
            K_REG:   act = dut.sccpu.cpu_ref.array_reg[e.idx[4:0]];
            default: act = dut.dmem[e.idx[9:0]];
         endcase
         n_chk++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     e.name, act, e.exp);
         end
      end
   end

   task automatic expect_v(input int kind, input int idx,
                           input logic [31:0] v,
                           input string name);
      exp_t e;
      e.kind = kind;
      e.idx  = idx;
      e.exp  = v;
      e.name = name;
      sbq.push_back(e);
   endtask

   task automatic sync();
      for (int i = 0; i < 4 && sbq.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (sbq.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL sync: %0d checks left, required 0",
                  sbq.size());
         sbq.delete();
      end
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         dut.imem[i] = 32'h0;
      end
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_arith();
      dut.imem[0] = i_op(6'h0f, 0, 1, 16'h1234);
      dut.imem[1] = i_op(6'h0d, 1, 1, 16'h5678);
      dut.imem[2] = i_op(6'h09, 0, 2, 16'hffff);
      dut.imem[3] = r_op(1, 2, 3, 0, 6'h21);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit hit");
      $fatal(1);
   end

   initial begin
      // reset state while reset is held
      hold_reset();
      load_arith();
      #1;
      expect_v(K_PC, 0, 32'h0040_0000, "rst_pc");
      expect_v(K_INST, 0, i_op(6'h0f, 0, 1, 16'h1234),
               "rst_inst");
      expect_v(K_REG, 1, 32'h0, "rst_r1");
      expect_v(K_REG, 31, 32'h0, "rst_r31");
      sync();
      release_reset();

      // lui/ori/addiu/addu
      run(4);
      expect_v(K_REG, 1, 32'h1234_5678, "ar_r1");
      expect_v(K_REG, 2, 32'hffff_ffff, "ar_r2");
      expect_v(K_REG, 3, 32'h1234_5677, "ar_r3");
      expect_v(K_PC, 0, 32'h0040_0010, "ar_pc");
      sync();

      // shifts, compares, v-forms, subu, nor
      hold_reset();
      dut.imem[0] = i_op(6'h09, 0, 4, 16'hfff8);
      dut.imem[1] = r_op(0, 4, 5, 1, 6'h03);
      dut.imem[2] = r_op(0, 4, 6, 28, 6'h02);
      dut.imem[3] = r_op(4, 0, 7, 0, 6'h2a);
      dut.imem[4] = r_op(4, 0, 8, 0, 6'h2b);
      dut.imem[5] = r_op(7, 6, 9, 0, 6'h04);
      dut.imem[6] = r_op(0, 0, 10, 0, 6'h27);
      dut.imem[7] = r_op(6, 7, 11, 0, 6'h23);
      release_reset();
      run(8);
      expect_v(K_REG, 5, 32'hffff_fffc, "sra");
      expect_v(K_REG, 6, 32'h0000_000f, "srl");
      expect_v(K_REG, 7, 32'h1, "slt");
      expect_v(K_REG, 8, 32'h0, "sltu");
      expect_v(K_REG, 9, 32'h0000_001e, "sllv");
      expect_v(K_REG, 10, 32'hffff_ffff, "nor");
      expect_v(K_REG, 11, 32'h0000_000e, "subu");
      sync();

      // memory path, immediates, RAM index wrap
      hold_reset();
      dut.dmem[1] = 32'h0;
      dut.dmem[2] = 32'h0;
      dut.imem[0] = i_op(6'h0f, 0, 9, 16'h1001);
      dut.imem[1] = i_op(6'h09, 0, 10, 16'h0055);
      dut.imem[2] = i_op(6'h2b, 9, 10, 16'h0004);
      dut.imem[3] = i_op(6'h23, 9, 11, 16'h0004);
      dut.imem[4] = i_op(6'h0b, 0, 12, 16'hffff);
      dut.imem[5] = i_op(6'h0c, 10, 13, 16'h000f);
      dut.imem[6] = i_op(6'h0e, 10, 14, 16'hffff);
      dut.imem[7] = i_op(6'h2b, 9, 10, 16'h1008);
      dut.imem[8] = i_op(6'h23, 9, 15, 16'h100b);
      release_reset();
      run(9);
      expect_v(K_REG, 11, 32'h0000_0055, "lw");
      expect_v(K_MEM, 1, 32'h0000_0055, "sw");
      expect_v(K_REG, 12, 32'h1, "sltiu");
      expect_v(K_REG, 13, 32'h0000_0005, "andi");
      expect_v(K_REG, 14, 32'h0000_ffaa, "xori");
      expect_v(K_MEM, 2, 32'h0000_0055, "sw_wrap");
      expect_v(K_REG, 15, 32'h0000_0055, "lw_wrap");
      sync();

      // control flow, stepped one edge at a time
      hold_reset();
      dut.imem[0]  = i_op(6'h04, 0, 0, 16'h0002);
      dut.imem[3]  = j_op(6'h03, 32'h0040_0100);
      dut.imem[64] = i_op(6'h09, 0, 0, 16'h0005);
      dut.imem[65] = r_op(31, 0, 0, 0, 6'h08);
      dut.imem[4]  = i_op(6'h05, 0, 0, 16'h0005);
      dut.imem[5]  = i_op(6'h09, 0, 1, 16'h0007);
      dut.imem[6]  = i_op(6'h05, 1, 0, 16'h0001);
      dut.imem[7]  = i_op(6'h09, 0, 2, 16'h0009);
      dut.imem[8]  = j_op(6'h02, 32'h0040_0000);
      release_reset();
      run(1);
      expect_v(K_PC, 0, 32'h0040_000c, "beq_pc");
      sync();
      run(1);
      expect_v(K_PC, 0, 32'h0040_0100, "jal_pc");
      expect_v(K_REG, 31, 32'h0040_0010, "jal_ra");
      sync();
      run(1);
      expect_v(K_REG, 0, 32'h0, "r0_zero");
      sync();
      run(1);
      expect_v(K_PC, 0, 32'h0040_0010, "jr_pc");
      sync();
      run(1);
      expect_v(K_PC, 0, 32'h0040_0014, "bne_nt_pc");
      sync();
      run(2);
      expect_v(K_PC, 0, 32'h0040_0020, "bne_t_pc");
      expect_v(K_REG, 2, 32'h0, "skipped");
      sync();
      run(1);
      expect_v(K_PC, 0, 32'h0040_0000, "j_pc");
      sync();

      // asynchronous reset between edges
      hold_reset();
      load_arith();
      release_reset();
      run(3);
      rst_n = 1'b0;
      #1;
      expect_v(K_PC, 0, 32'h0040_0000, "arst_pc");
      expect_v(K_REG, 1, 32'h0, "arst_r1");
      expect_v(K_REG, 2, 32'h0, "arst_r2");
      sync();
      release_reset();
      run(4);
      expect_v(K_REG, 3, 32'h1234_5677, "resume_r3");
      expect_v(K_PC, 0, 32'h0040_0010, "resume_pc");
      sync();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
